// File: rtl/irq_ctrl_6502_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl_6502_pkg
// Brief    : Register map, bus constants and priority helper for irq_ctrl_6502
// Revision : 1.0  initial release
// ============================================================================
package irq_ctrl_6502_pkg;

  // Register offsets inside the controller's 8-byte window (rs = addr[2:0])
  localparam logic [2:0] IRQC_STATUS = 3'd0;
  localparam logic [2:0] IRQC_MASK   = 3'd1;
  localparam logic [2:0] IRQC_MODE   = 3'd2;
  localparam logic [2:0] IRQC_POLAR  = 3'd3;
  localparam logic [2:0] IRQC_VECTOR = 3'd4;
  localparam logic [2:0] IRQC_CLEAR  = 3'd5;

  localparam int VECTOR_VALID_BIT = 7;

  // Default I/O placement shared with the system address decoder
  localparam logic [15:0] IO_PAGE_BASE = 16'hFE00;
  localparam logic [15:0] IRQC_IO_BASE = 16'hFE38;

  localparam int NMI_PULSE_CLKS = 4;

  // Returns {valid, idx}: idx is the lowest set bit of vec (channel 0 wins)
  function automatic logic [3:0] prio_lowest(input logic [7:0] vec);
    logic [3:0] res;
    res = 4'h0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) res = {1'b1, 3'(i)};
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_ctrl_6502_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl_6502_sync_edge
// Brief    : Per-channel input synchroniser, polarity fold and rising-edge detect
// Revision : 1.0  initial release
// ============================================================================
module irq_ctrl_6502_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic res_n,
  input  logic i_src,
  input  logic i_polar,
  output logic o_act,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_act_q;

  // r_act_q resets high: with the chain cleared and POLAR=0 the channel looks
  // active straight out of reset, and that must not count as a rising edge.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_sync  <= '0;
      r_act_q <= 1'b1;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_src};
      r_act_q <= o_act;
    end
  end

  assign o_act  = r_sync[SYNC_STAGES-1] ^ ~i_polar;
  assign o_rise = o_act & ~r_act_q;

endmodule
`default_nettype wire

// File: rtl/irq_ctrl_6502.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl_6502
// Brief    : 6502-bus interrupt controller: sync, polarity, edge/level, mask,
//            pending latch, priority vector and combined irq_n. Define
//            IRQ_NMI_EN to move channel 0 onto a 4-clock nmi_n pulse.
// Revision : 1.0  initial release
// ============================================================================
module irq_ctrl_6502 #(
  parameter int N_CH        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            fst_clk,
  input  logic            res_n,
  input  logic            phi2,
  input  logic            cs_n,
  input  logic            rw_n,
  input  logic [2:0]      rs,
  input  logic [7:0]      din,
  output logic [7:0]      dout,
  input  logic [N_CH-1:0] irq_src,
  output logic            irq_n,
  output logic            nmi_n
);

  import irq_ctrl_6502_pkg::*;

  logic            r_phi2_q;
  logic [N_CH-1:0] r_mask;
  logic [N_CH-1:0] r_mode;
  logic [N_CH-1:0] r_polar;
  logic [N_CH-1:0] r_pending;
  logic            r_irq_n;

  logic            w_bus_cyc;
  logic            w_wr;
  logic            w_rd_vector;
  logic            w_wr_mask;
  logic            w_wr_mode;
  logic            w_wr_polar;
  logic            w_wr_clear;

  logic [N_CH-1:0] w_act;
  logic [N_CH-1:0] w_rise;
  logic [N_CH-1:0] w_mode_nxt;
  logic [N_CH-1:0] w_mode_eff;
  logic [N_CH-1:0] w_mode_nxt_eff;
  logic [N_CH-1:0] w_irq_mask;
  logic [N_CH-1:0] w_clr_wr;
  logic [N_CH-1:0] w_clr;
  logic [N_CH-1:0] w_pend_nxt;

  logic [7:0]      w_status8;
  logic [7:0]      w_mask8;
  logic [7:0]      w_mode8;
  logic [7:0]      w_polar8;
  logic [7:0]      w_pend_en8;
  logic [7:0]      w_ack8;
  logic [3:0]      w_prio;
  logic            w_vec_valid;
  logic [2:0]      w_vec_idx;

  // --------------------------------------------------------------------------
  // Bus strobe: one fst_clk pulse at the phi2 falling edge of a selected access
  // --------------------------------------------------------------------------
  assign w_bus_cyc   = r_phi2_q & ~phi2 & ~cs_n;
  assign w_wr        = w_bus_cyc & ~rw_n;
  assign w_rd_vector = w_bus_cyc & rw_n & (rs == IRQC_VECTOR);
  assign w_wr_mask   = w_wr & (rs == IRQC_MASK);
  assign w_wr_mode   = w_wr & (rs == IRQC_MODE);
  assign w_wr_polar  = w_wr & (rs == IRQC_POLAR);
  assign w_wr_clear  = w_wr & (rs == IRQC_CLEAR);

  // --------------------------------------------------------------------------
  // Input path, one synchroniser/edge detector per channel
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      irq_ctrl_6502_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_sync_edge (
        .clk     (fst_clk),
        .res_n   (res_n),
        .i_src   (irq_src[gi]),
        .i_polar (r_polar[gi]),
        .o_act   (w_act[gi]),
        .o_rise  (w_rise[gi])
      );
    end
  endgenerate

  assign w_mode_nxt = w_wr_mode ? din[N_CH-1:0] : r_mode;

`ifdef IRQ_NMI_EN
  localparam logic [N_CH-1:0] c_ch0 = N_CH'(1);

  logic [2:0] r_nmi_cnt;

  // Channel 0 is always edge-latched and never reaches the IRQ tree or VECTOR
  assign w_mode_eff     = r_mode | c_ch0;
  assign w_mode_nxt_eff = w_mode_nxt | c_ch0;
  assign w_irq_mask     = r_mask & ~c_ch0;

  always_ff @(posedge fst_clk or negedge res_n) begin
    if (!res_n) begin
      r_nmi_cnt <= 3'd0;
    end else if (w_rise[0]) begin
      r_nmi_cnt <= 3'(NMI_PULSE_CLKS);
    end else if (r_nmi_cnt != 3'd0) begin
      r_nmi_cnt <= r_nmi_cnt - 3'd1;
    end
  end

  assign nmi_n = (r_nmi_cnt == 3'd0);
`else
  assign w_mode_eff     = r_mode;
  assign w_mode_nxt_eff = w_mode_nxt;
  assign w_irq_mask     = r_mask;
  assign nmi_n          = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Priority vector over enabled pending channels
  // --------------------------------------------------------------------------
  always_comb begin
    w_status8  = 8'h00;
    w_mask8    = 8'h00;
    w_mode8    = 8'h00;
    w_polar8   = 8'h00;
    w_pend_en8 = 8'h00;
    w_status8[N_CH-1:0]  = r_pending;
    w_mask8[N_CH-1:0]    = r_mask;
    w_mode8[N_CH-1:0]    = r_mode;
    w_polar8[N_CH-1:0]   = r_polar;
    w_pend_en8[N_CH-1:0] = r_pending & w_irq_mask;
  end

  assign w_prio      = prio_lowest(w_pend_en8);
  assign w_vec_valid = w_prio[3];
  assign w_vec_idx   = w_prio[2:0];

  always_comb begin
    w_ack8 = 8'h00;
    if (w_rd_vector && w_vec_valid) w_ack8[w_vec_idx] = 1'b1;
  end

  assign w_clr_wr = w_wr_clear ? din[N_CH-1:0] : '0;
  assign w_clr    = w_clr_wr | w_ack8[N_CH-1:0];

  // --------------------------------------------------------------------------
  // Pending update: level follows act; edge latches with set winning over
  // clear; a 0->1 MODE switch drops the old level so a fresh edge is needed.
  // --------------------------------------------------------------------------
  always_comb begin
    w_pend_nxt = r_pending;
    for (int i = 0; i < N_CH; i++) begin
      if (!w_mode_nxt_eff[i]) begin
        w_pend_nxt[i] = w_act[i];
      end else if (!w_mode_eff[i]) begin
        w_pend_nxt[i] = w_rise[i];
      end else begin
        w_pend_nxt[i] = (r_pending[i] & ~w_clr[i]) | w_rise[i];
      end
    end
  end

  always_ff @(posedge fst_clk or negedge res_n) begin
    if (!res_n) begin
      r_phi2_q  <= 1'b0;
      r_mask    <= '0;
      r_mode    <= '0;
      r_polar   <= '0;
      r_pending <= '0;
      r_irq_n   <= 1'b1;
    end else begin
      r_phi2_q  <= phi2;
      r_mode    <= w_mode_nxt;
      if (w_wr_mask)  r_mask  <= din[N_CH-1:0];
      if (w_wr_polar) r_polar <= din[N_CH-1:0];
      r_pending <= w_pend_nxt;
      r_irq_n   <= ~|(r_pending & w_irq_mask);
    end
  end

  assign irq_n = r_irq_n;

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  always_comb begin
    dout = 8'h00;
    case (rs)
      IRQC_STATUS: dout = w_status8;
      IRQC_MASK:   dout = w_mask8;
      IRQC_MODE:   dout = w_mode8;
      IRQC_POLAR:  dout = w_polar8;
      IRQC_VECTOR: begin
        dout[VECTOR_VALID_BIT] = w_vec_valid;
        dout[2:0]              = w_vec_idx;
      end
      default:     dout = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl_6502.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_ctrl_6502
// Brief    : Self-checking bench for irq_ctrl_6502 (register table, directed
//            corner sequences, randomized ops against a transaction model)
// Revision : 1.0  initial release
// ============================================================================
module tb_irq_ctrl_6502;

  localparam logic [2:0] c_rs_status = 3'd0;
  localparam logic [2:0] c_rs_mask   = 3'd1;
  localparam logic [2:0] c_rs_mode   = 3'd2;
  localparam logic [2:0] c_rs_polar  = 3'd3;
  localparam logic [2:0] c_rs_vector = 3'd4;
  localparam logic [2:0] c_rs_clear  = 3'd5;

  logic       clk = 1'b0;
  logic       res_n;
  logic       phi2;
  logic       cs_n;
  logic       rw_n;
  logic [2:0] rs;
  logic [7:0] din;
  logic [7:0] dout;
  logic [7:0] irq_src;
  logic       irq_n;
  logic       nmi_n;

  int checks = 0;
  int errors = 0;

  irq_ctrl_6502 #(.N_CH(8), .SYNC_STAGES(2)) dut (
    .fst_clk (clk),
    .res_n   (res_n),
    .phi2    (phi2),
    .cs_n    (cs_n),
    .rw_n    (rw_n),
    .rs      (rs),
    .din     (din),
    .dout    (dout),
    .irq_src (irq_src),
    .irq_n   (irq_n),
    .nmi_n   (nmi_n)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%02h exp=%02h", name, got, exp);
    end
  endtask

  // One fst_clk period, ending on the falling edge where we drive and sample
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input logic [7:0] idle);
    res_n = 1'b0; irq_src = idle; cs_n = 1'b1; rw_n = 1'b1;
    phi2 = 1'b0; rs = 3'd0; din = 8'h00;
    cyc(2);
    res_n = 1'b1;
    cyc(4);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    cs_n = 1'b0; rw_n = 1'b0; rs = a; din = d; phi2 = 1'b1;
    cyc(1);
    phi2 = 1'b0;
    cyc(1);
    cs_n = 1'b1; rw_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    cs_n = 1'b0; rw_n = 1'b1; rs = a; phi2 = 1'b1;
    cyc(1);
    phi2 = 1'b0;
    #1 d = dout;
    @(posedge clk);
    @(negedge clk);
    cs_n = 1'b1;
  endtask

  // ---------------- transaction-level reference model ----------------------
  logic [7:0] m_mask, m_mode, m_polar, m_pend, m_act, src_v;

  task automatic m_eval_act();
    logic [7:0] a, rise;
    a      = src_v ^ ~m_polar;
    rise   = a & ~m_act;
    m_pend = ((m_pend | rise) & m_mode) | (a & ~m_mode);
    m_act  = a;
  endtask

  task automatic m_wr_mode(input logic [7:0] d);
    logic [7:0] newly_edge;
    newly_edge = d & ~m_mode;
    m_pend = (m_pend & d & ~newly_edge) | (m_act & ~d);
    m_mode = d;
  endtask

  function automatic logic [7:0] m_vec(input logic [7:0] p, input logic [7:0] m);
    for (int i = 0; i < 8; i++) begin
      if (p[i] && m[i]) return 8'h80 | 8'(i);
    end
    return 8'h00;
  endfunction

  typedef struct {
    logic       wr;
    logic [2:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[22];

  initial begin
    logic [7:0] rd;
    logic [7:0] d;
    logic [7:0] exp_v;
    int         op;
    int         lowcnt;
    int         irqlow;

    tbl[0]  = '{1'b0, c_rs_status, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, c_rs_mask,   8'h00, 8'h00};
    tbl[2]  = '{1'b0, c_rs_mode,   8'h00, 8'h00};
    tbl[3]  = '{1'b0, c_rs_polar,  8'h00, 8'h00};
    tbl[4]  = '{1'b0, c_rs_vector, 8'h00, 8'h00};
    tbl[5]  = '{1'b0, 3'd6,        8'h00, 8'h00};
    tbl[6]  = '{1'b0, 3'd7,        8'h00, 8'h00};
    tbl[7]  = '{1'b1, c_rs_mask,   8'h5A, 8'h00};
    tbl[8]  = '{1'b0, c_rs_mask,   8'h00, 8'h5A};
    tbl[9]  = '{1'b1, c_rs_mode,   8'hC3, 8'h00};
    tbl[10] = '{1'b0, c_rs_mode,   8'h00, 8'hC3};
    tbl[11] = '{1'b1, 3'd6,        8'hFF, 8'h00};
    tbl[12] = '{1'b0, 3'd6,        8'h00, 8'h00};
    tbl[13] = '{1'b1, c_rs_status, 8'hFF, 8'h00};
    tbl[14] = '{1'b0, c_rs_status, 8'h00, 8'h00};
    tbl[15] = '{1'b1, c_rs_clear,  8'hFF, 8'h00};
    tbl[16] = '{1'b0, c_rs_clear,  8'h00, 8'h00};
    tbl[17] = '{1'b0, c_rs_mask,   8'h00, 8'h5A};
    tbl[18] = '{1'b1, c_rs_mask,   8'h00, 8'h00};
    tbl[19] = '{1'b0, c_rs_mask,   8'h00, 8'h00};
    tbl[20] = '{1'b1, c_rs_mode,   8'h00, 8'h00};
    tbl[21] = '{1'b0, c_rs_mode,   8'h00, 8'h00};

    // Peripheral lines are active-low, so idle is all-ones
    res_n = 1'b0; irq_src = 8'hFF; cs_n = 1'b1; rw_n = 1'b1;
    phi2 = 1'b0; rs = 3'd0; din = 8'h00;
    cyc(1);
    check8("rst_irq_n", {7'b0, irq_n}, 8'h01);
    check8("rst_nmi_n", {7'b0, nmi_n}, 8'h01);
    do_reset(8'hFF);

    // ---- register table ----
    for (int i = 0; i < 22; i++) begin
      if (tbl[i].wr) begin
        bus_write(tbl[i].a, tbl[i].d);
      end else begin
        bus_read(tbl[i].a, rd);
        check8($sformatf("tbl%0d_rs%0d", i, tbl[i].a), rd, tbl[i].exp);
      end
    end
    check8("tbl_irq_n", {7'b0, irq_n}, 8'h01);

    // ---- ch2 edge, active-high: latency and VECTOR ack ----
    do_reset(8'hFB);
    bus_write(c_rs_polar, 8'h04);
    bus_write(c_rs_mode,  8'h04);
    bus_write(c_rs_mask,  8'h04);
    cyc(2);
    bus_read(c_rs_status, rd);
    check8("t2_status_idle", rd, 8'h00);
    irq_src[2] = 1'b1;
    cyc(1);
    irq_src[2] = 1'b0;
    cyc(2);
    check8("t2_irq_n_clk3", {7'b0, irq_n}, 8'h01);
    cyc(1);
    check8("t2_irq_n_clk4", {7'b0, irq_n}, 8'h00);
    check8("t2_nmi_n", {7'b0, nmi_n}, 8'h01);
    bus_read(c_rs_vector, rd);
    check8("t2_vector", rd, 8'h82);
    bus_read(c_rs_status, rd);
    check8("t2_status_acked", rd, 8'h00);
    check8("t2_irq_n_released", {7'b0, irq_n}, 8'h01);

    // ---- level mode, active-low, two channels ----
    do_reset(8'hFF);
    bus_write(c_rs_mask, 8'h0A);
    irq_src = 8'hF5;
    cyc(5);
    check8("t3_irq_n_low", {7'b0, irq_n}, 8'h00);
    bus_read(c_rs_vector, rd);
    check8("t3_vector_ch1", rd, 8'h81);
    irq_src = 8'hF7;
    cyc(5);
    bus_read(c_rs_vector, rd);
    check8("t3_vector_ch3", rd, 8'h83);
    irq_src = 8'hFF;
    cyc(5);
    check8("t3_irq_n_high", {7'b0, irq_n}, 8'h01);
    bus_read(c_rs_vector, rd);
    check8("t3_vector_none", rd, 8'h00);

    // ---- new edge on ch5 in the same clock as CLEAR of ch5 ----
    do_reset(8'hDF);
    bus_write(c_rs_polar, 8'h20);
    bus_write(c_rs_mode,  8'h20);
    bus_write(c_rs_mask,  8'h20);
    cyc(2);
    irq_src[5] = 1'b1;
    cyc(1);
    cs_n = 1'b0; rw_n = 1'b0; rs = c_rs_clear; din = 8'h20; phi2 = 1'b1;
    cyc(1);
    phi2 = 1'b0;
    cyc(1);
    cs_n = 1'b1; rw_n = 1'b1;
    bus_read(c_rs_status, rd);
    check8("t4_set_wins", rd, 8'h20);
    check8("t4_irq_n", {7'b0, irq_n}, 8'h00);
    bus_write(c_rs_clear, 8'h20);
    bus_read(c_rs_status, rd);
    check8("t4_cleared", rd, 8'h00);
    irq_src = 8'hDF;

    // ---- masked latch, then unmask ----
    do_reset(8'hBF);
    bus_write(c_rs_polar, 8'h40);
    bus_write(c_rs_mode,  8'h40);
    cyc(2);
    irq_src[6] = 1'b1;
    cyc(1);
    irq_src[6] = 1'b0;
    cyc(5);
    bus_read(c_rs_status, rd);
    check8("t5_status_masked", rd, 8'h40);
    check8("t5_irq_n_masked", {7'b0, irq_n}, 8'h01);
    bus_write(c_rs_mask, 8'h40);
    check8("t5_irq_n_commit", {7'b0, irq_n}, 8'h01);
    cyc(1);
    check8("t5_irq_n_next", {7'b0, irq_n}, 8'h00);

    // ---- async reset in the middle of a write ----
    do_reset(8'hFF);
    cs_n = 1'b0; rw_n = 1'b0; rs = c_rs_mask; din = 8'hFF; phi2 = 1'b1;
    cyc(1);
    phi2 = 1'b0;
    #1 res_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cs_n = 1'b1; rw_n = 1'b1;
    res_n = 1'b1;
    cyc(4);
    bus_read(c_rs_mask, rd);
    check8("t7_reset_abort", rd, 8'h00);

`ifdef IRQ_NMI_EN
    // ---- channel 0 as NMI ----
    do_reset(8'hFF);
    irq_src[0] = 1'b0;
    cyc(1);
    irq_src[0] = 1'b1;
    lowcnt = 0;
    irqlow = 0;
    for (int k = 0; k < 14; k++) begin
      cyc(1);
      if (!nmi_n) lowcnt++;
      if (!irq_n) irqlow++;
    end
    check8("t6_nmi_len", 8'(lowcnt), 8'd4);
    check8("t6_irq_quiet", 8'(irqlow), 8'd0);
    bus_read(c_rs_vector, rd);
    check8("t6_vector", rd, 8'h00);
    bus_read(c_rs_status, rd);
    check8("t6_status", rd, 8'h01);
    bus_write(c_rs_clear, 8'h01);
    bus_read(c_rs_status, rd);
    check8("t6_cleared", rd, 8'h00);
`else
    // ---- randomized register/source traffic against the model ----
    do_reset(8'hFF);
    m_mask = 8'h00; m_mode = 8'h00; m_polar = 8'h00;
    m_pend = 8'h00; m_act = 8'h00; src_v = 8'hFF;
    for (int it = 0; it < 80; it++) begin
      op = int'($urandom_range(0, 6));
      d  = 8'($urandom);
      case (op)
        0: begin irq_src = d; src_v = d; m_eval_act(); end
        1: begin bus_write(c_rs_mask, d); m_mask = d; end
        2: begin bus_write(c_rs_mode, d); m_wr_mode(d); end
        3: begin bus_write(c_rs_polar, d); m_polar = d; m_eval_act(); end
        4: begin bus_write(c_rs_clear, d); m_pend = m_pend & ~(d & m_mode); end
        5: begin
          exp_v = m_vec(m_pend, m_mask);
          bus_read(c_rs_vector, rd);
          check8($sformatf("rnd%0d_vector", it), rd, exp_v);
          if (exp_v[7] && m_mode[exp_v[2:0]]) m_pend[exp_v[2:0]] = 1'b0;
        end
        default: begin
          bus_read(c_rs_status, rd);
          check8($sformatf("rnd%0d_status", it), rd, m_pend);
        end
      endcase
      cyc(5);
      check8($sformatf("rnd%0d_irq_n", it), {7'b0, irq_n}, {7'b0, ~|(m_pend & m_mask)});
    end
    check8("rnd_nmi_n", {7'b0, nmi_n}, 8'h01);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
